alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits.
REQ-002 Parameter DEPTH, default 4, number of buffered operand sets; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream offers one operand set.
REQ-006 in_ready  output  1  stage can accept an operand set this cycle.
REQ-007 in1_i  input  WIDTH  first operand.
REQ-008 in2_i  input  WIDTH  second operand.
REQ-009 op_i  input  3  logic-op select (AND, OR, XOR, XNOR, NAND, NOR, NOT, PASS), carried opaquely.
REQ-010 flush  input  1  synchronous discard of all buffered sets.
REQ-011 out_valid  output  1  head operand set is presented to the logic unit.
REQ-012 out_ready  input  1  logic unit consumes head set this cycle.
REQ-013 in1  output  WIDTH  head first operand, driven to logic-gate in1.
REQ-014 in2  output  WIDTH  head second operand, driven to logic-gate in2.
REQ-015 op  output  3  head op select.
REQ-016 level  output  $clog2(DEPTH)+1  number of buffered sets.

Function
REQ-017 Push occurs when in_valid and in_ready are both high at a rising edge.
REQ-018 Pop occurs when out_valid and out_ready are both high at a rising edge.
REQ-019 in_ready SHALL equal (level != DEPTH); no pass-through when full, even with concurrent pop.
REQ-020 out_valid SHALL equal (level != 0); a set pushed into an empty stage is visible exactly one cycle after the push edge.
REQ-021 in1/in2/op SHALL be the oldest buffered set, FIFO order, stable while out_valid high and out_ready low.
REQ-022 Concurrent push and pop with 0 < level < DEPTH: level unchanged, both transfers take effect.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; level never exceeds DEPTH or goes below 0.
REQ-024 When out_valid is low, in1/in2/op SHALL hold last popped values (zero if none since reset).
REQ-025 flush high: pointers and level cleared at the edge; any same-cycle push or pop is ignored; out_valid low the following cycle.
REQ-026 in_valid while in_ready low: no state change, upstream holds data.

Reset
REQ-027 rst_n low asynchronously clears pointers, level=0, in_ready=1, out_valid=0, in1=in2=0, op=0, storage=0.
REQ-028 Reset mid-transfer discards all buffered sets; first edge after rst_n deassertion behaves as from empty.

Configuration
REQ-029 Macro ALU_OPSTAGE_COUNT_EN, when defined, adds output accepted_cnt (16 bits): count of pushes, wraps 0xFFFF->0x0000, cleared by reset, not by flush.
REQ-030 Without ALU_OPSTAGE_COUNT_EN, port accepted_cnt and its counter do not exist; all other behaviour identical.

Structure
REQ-031 Package alu_pkg holds ALU_WIDTH=16, OP_W=3, and the op-select enumeration shared with the logic unit.
REQ-032 Storage array is sub-module alu_opstage_mem (DEPTH x (2*WIDTH+3), registered write, combinational read); pointer/level control stays in alu_operand_stage.

Verification
REQ-033 Reset, then push {in1=0x00FF, in2=0x0F0F, op=XNOR} -> out_valid rises one cycle later, in1=0x00FF, in2=0x0F0F, level=1.
REQ-034 out_ready=0, push 4 sets -> level=4, in_ready=0; 5th in_valid ignored; then out_ready=1 -> 4 pops in push order, level 4->0.
REQ-035 Level=2, push and pop same cycle for 10 cycles with random $random operands -> level stays 2, output order matches input order across pointer wrap.
REQ-036 Level=3, flush with in_valid=1 -> next cycle level=0, out_valid=0, pushed set absent.
REQ-037 rst_n pulsed low mid-cycle with level=2 -> outputs zero immediately, in_ready=1 without waiting for clk.
REQ-038 With ALU_OPSTAGE_COUNT_EN, 65537 pushes -> accepted_cnt=0x0001; flush leaves accepted_cnt unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths and the logic-op select encoding
package alu_pkg;
  localparam int ALU_WIDTH = 16;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NAND, OP_NOR, OP_NOT, OP_PASS
  } op_e;
endpackage

// File: rtl/alu_opstage_mem.sv
// alu_opstage_mem: operand-set storage, registered write and combinational read
module alu_opstage_mem import alu_pkg::*; #(
  parameter int DW = 2 * ALU_WIDTH + OP_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: FIFO operand buffer ahead of the logic unit; ALU_OPSTAGE_COUNT_EN adds accepted_cnt
module alu_operand_stage import alu_pkg::*; #(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in1_i,
  input  logic [WIDTH-1:0]       in2_i,
  input  logic [OP_W-1:0]        op_i,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       in1,
  output logic [WIDTH-1:0]       in2,
  output logic [OP_W-1:0]        op,
  output logic [$clog2(DEPTH):0] level
`ifdef ALU_OPSTAGE_COUNT_EN
  ,
  output logic [15:0]            accepted_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = 2 * WIDTH + OP_W;
  logic [AW-1:0] wptr, rptr;
  logic [DW-1:0] rdata, last;
  logic push, pop;
  assign in_ready  = level != LW'(DEPTH);
  assign out_valid = level != '0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  // an empty stage keeps showing the most recently consumed set
  assign {in1, in2, op} = out_valid ? rdata : last;
  alu_opstage_mem #(.DW(DW), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wptr),
    .raddr (rptr),
    .wdata ({in1_i, in2_i, op_i}),
    .rdata (rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      last  <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr <= rptr + AW'(1);
        last <= rdata;
      end
      level <= level + LW'(push) - LW'(pop);
    end
  end
`ifdef ALU_OPSTAGE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) accepted_cnt <= '0;
    else if (push) accepted_cnt <= accepted_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed and random checks against a queue model
module tb_alu_operand_stage;
  import alu_pkg::*;
  localparam int W = 16;
  localparam int D = 4;
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   o;
  } set_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [W-1:0] in1_i = '0, in2_i = '0, in1, in2;
  logic [2:0] op_i = '0, op, level;
  int checks = 0, errors = 0;
  set_t q[$];
  set_t last = '0;
  int unsigned m_cnt = 0;
`ifdef ALU_OPSTAGE_COUNT_EN
  logic [15:0] accepted_cnt;
`endif

  alu_operand_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1_i     (in1_i),
    .in2_i     (in2_i),
    .op_i      (op_i),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in1       (in1),
    .in2       (in2),
    .op        (op),
    .level     (level)
`ifdef ALU_OPSTAGE_COUNT_EN
    ,
    .accepted_cnt (accepted_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    set_t h;
    h = (q.size() != 0) ? q[0] : last;
    chk({tag, ".level"}, 32'(level), 32'(q.size()));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() != D));
    chk({tag, ".in1"}, 32'(in1), 32'(h.a));
    chk({tag, ".in2"}, 32'(in2), 32'(h.b));
    chk({tag, ".op"}, 32'(op), 32'(h.o));
`ifdef ALU_OPSTAGE_COUNT_EN
    chk({tag, ".accepted_cnt"}, 32'(accepted_cnt), m_cnt);
`endif
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] o, input logic r, input logic f);
    in_valid = v; in1_i = a; in2_i = b; op_i = o; out_ready = r; flush = f;
  endtask

  task automatic drive_rand(input logic v, input logic r);
    drive(v, W'($urandom), W'($urandom), 3'($urandom), r, 1'b0);
  endtask

  task automatic cycle();
    bit pu, po;
    set_t s;
    s  = '{a: in1_i, b: in2_i, o: op_i};
    pu = in_valid && q.size() < D && !flush;
    po = q.size() != 0 && out_ready && !flush;
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (po) last = q.pop_front();
      if (pu) q.push_back(s);
    end
    if (pu) m_cnt = (m_cnt + 1) % 65536;
  endtask

  task automatic step(input string tag);
    cycle();
    compare_all(tag);
  endtask

  initial begin
    #12;
    compare_all("reset");
    rst_n = 1'b1;
    // single set into an empty stage
    drive(1'b1, 16'h00FF, 16'h0F0F, OP_XNOR, 1'b0, 1'b0);
    compare_all("pre_push");
    step("push1");
    chk("push1.in1_lit", 32'(in1), 32'h00FF);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step("pop1_hold");
    chk("hold.in2_lit", 32'(in2), 32'h0F0F);
    // fill to full, then refused fifth offer, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive_rand(1'b1, 1'b0);
      step("fill");
    end
    drive_rand(1'b1, 1'b0);
    step("full_refuse");
    drive_rand(1'b1, 1'b1);
    step("full_pop_no_pass");
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("drain");
    // steady level 2 with concurrent push/pop across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drive_rand(1'b1, 1'b0);
      step("lvl2_fill");
    end
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1, 1'b1);
      step("pushpop");
    end
    // flush ignores same-cycle push and pop
    drive_rand(1'b1, 1'b0);
    step("lvl3_fill");
    drive_rand(1'b1, 1'b1);
    flush = 1'b1;
    step("flush");
    flush = 1'b0;
    drive_rand(1'b0, 1'b0);
    step("post_flush");
    // random traffic
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom), W'($urandom), W'($urandom), 3'($urandom),
            1'($urandom), $urandom_range(0, 15) == 0);
      step("rand");
    end
    // asynchronous reset mid-cycle at level 2
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
    cycle();
    for (int i = 0; i < 2; i++) begin
      drive_rand(1'b1, 1'b0);
      step("pre_areset");
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    last = '0;
    m_cnt = 0;
    compare_all("areset");
    #1;
    rst_n = 1'b1;
    drive_rand(1'b1, 1'b0);
    step("after_areset");
`ifdef ALU_OPSTAGE_COUNT_EN
    drive_rand(1'b1, 1'b1);
    for (int i = 0; i < 65536; i++) cycle();
    compare_all("cnt_wrap");
    chk("cnt_wrap.lit", 32'(accepted_cnt), 32'h0001);
    flush = 1'b1;
    step("cnt_flush");
    chk("cnt_flush.lit", 32'(accepted_cnt), 32'h0001);
    flush = 1'b0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
